// File: rtl/ls_arbiter.sv
// ls_arbiter: single-port local-store arbiter for LSU / IF / DMA with fixed priority,
// an IF starvation guard and a DMA burst limit. Stall counters are built only with LS_ARB_PERF_EN.
module ls_arbiter #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned LS_AW         = 14,
   parameter int unsigned DATA_W        = 128,
   parameter int unsigned STARVE_MAX    = 8,
   parameter int unsigned DMA_BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_gnt,
   output logic              lsu_rvalid,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [LS_AW-1:0]  mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       perf_lsu_stall,
   output logic [31:0]       perf_if_stall,
   output logic [31:0]       perf_dma_stall
);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam int unsigned BW = $clog2(DMA_BURST_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [BW-1:0] BURST_TOP  = BW'(DMA_BURST_MAX);

   typedef enum logic [1:0] {OWN_NONE, OWN_LSU, OWN_IF, OWN_DMA} owner_t;

   logic [SW-1:0] r_if_starve;
   logic [BW-1:0] r_dma_run;
   owner_t        r_owner;
   logic          w_if_force;
   logic          w_dma_block;
   logic          w_lsu_gnt;
   logic          w_if_gnt;
   logic          w_dma_gnt;
   logic          w_unused_addr;

   // Grants are suppressed while reset is held so every grant and strobe reads 0.
   always_comb begin
      w_lsu_gnt   = 1'b0;
      w_if_gnt    = 1'b0;
      w_dma_gnt   = 1'b0;
      w_if_force  = if_req && (r_if_starve == STARVE_TOP);
      w_dma_block = (r_dma_run == BURST_TOP) && (lsu_req || if_req);
      if (reset) begin
         if (w_if_force)                  w_if_gnt  = 1'b1;
         else if (dma_req && !w_dma_block) w_dma_gnt = 1'b1;
         else if (lsu_req)                 w_lsu_gnt = 1'b1;
         else if (if_req)                  w_if_gnt  = 1'b1;
      end
   end

   always_comb begin
      mem_en    = w_lsu_gnt || w_if_gnt || w_dma_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_dma_gnt) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr[LS_AW+3:4];
         mem_wdata = dma_wdata;
      end else if (w_lsu_gnt) begin
         mem_we    = lsu_we;
         mem_addr  = lsu_addr[LS_AW+3:4];
         mem_wdata = lsu_wdata;
      end else if (w_if_gnt) begin
         mem_addr  = if_addr[LS_AW+3:4];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_if_starve <= '0;
         r_dma_run   <= '0;
         r_owner     <= OWN_NONE;
      end else begin
         if (!if_req || w_if_gnt)         r_if_starve <= '0;
         else if (r_if_starve != STARVE_TOP) r_if_starve <= r_if_starve + 1'b1;

         // A blocked cycle carries no DMA grant, so the run restarts from zero.
         if (!w_dma_gnt)                  r_dma_run <= '0;
         else if (r_dma_run != BURST_TOP) r_dma_run <= r_dma_run + 1'b1;

         if (w_dma_gnt && !dma_we)        r_owner <= OWN_DMA;
         else if (w_lsu_gnt && !lsu_we)   r_owner <= OWN_LSU;
         else if (w_if_gnt)               r_owner <= OWN_IF;
         else                             r_owner <= OWN_NONE;
      end
   end

   assign lsu_gnt    = w_lsu_gnt;
   assign if_gnt     = w_if_gnt;
   assign dma_gnt    = w_dma_gnt;
   assign lsu_rvalid = (r_owner == OWN_LSU);
   assign if_rvalid  = (r_owner == OWN_IF);
   assign dma_rvalid = (r_owner == OWN_DMA);
   assign rdata      = (r_owner != OWN_NONE) ? mem_rdata : '0;

   assign w_unused_addr = &{1'b0,
                            lsu_addr[ADDR_W-1:LS_AW+4], lsu_addr[3:0],
                            if_addr[ADDR_W-1:LS_AW+4],  if_addr[3:0],
                            dma_addr[ADDR_W-1:LS_AW+4], dma_addr[3:0]};

`ifdef LS_ARB_PERF_EN
   logic [31:0] r_perf_lsu;
   logic [31:0] r_perf_if;
   logic [31:0] r_perf_dma;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perf_lsu <= '0;
         r_perf_if  <= '0;
         r_perf_dma <= '0;
      end else begin
         if (lsu_req && !w_lsu_gnt) r_perf_lsu <= r_perf_lsu + 32'd1;
         if (if_req  && !w_if_gnt)  r_perf_if  <= r_perf_if  + 32'd1;
         if (dma_req && !w_dma_gnt) r_perf_dma <= r_perf_dma + 32'd1;
      end
   end

   assign perf_lsu_stall = r_perf_lsu;
   assign perf_if_stall  = r_perf_if;
   assign perf_dma_stall = r_perf_dma;
`else
   assign perf_lsu_stall = '0;
   assign perf_if_stall  = '0;
   assign perf_dma_stall = '0;
`endif

endmodule

// File: tb/tb_ls_arbiter.sv
// Self-checking bench for ls_arbiter: vector table, directed corner sequences and
// randomized traffic against a rule-level reference model.
module tb_ls_arbiter;
   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned LS_AW         = 14;
   localparam int unsigned DATA_W        = 128;
   localparam int unsigned STARVE_MAX    = 8;
   localparam int unsigned DMA_BURST_MAX = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              lsu_req = 1'b0, lsu_we = 1'b0;
   logic [ADDR_W-1:0] lsu_addr = '0;
   logic [DATA_W-1:0] lsu_wdata = '0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              dma_req = 1'b0, dma_we = 1'b0;
   logic [ADDR_W-1:0] dma_addr = '0;
   logic [DATA_W-1:0] dma_wdata = '0;
   logic              lsu_gnt, lsu_rvalid, if_gnt, if_rvalid, dma_gnt, dma_rvalid;
   logic [DATA_W-1:0] rdata;
   logic              mem_en, mem_we;
   logic [LS_AW-1:0]  mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [31:0]       perf_lsu_stall, perf_if_stall, perf_dma_stall;

   always #5 clk = ~clk;

   ls_arbiter #(.ADDR_W(ADDR_W), .LS_AW(LS_AW), .DATA_W(DATA_W),
                .STARVE_MAX(STARVE_MAX), .DMA_BURST_MAX(DMA_BURST_MAX)) dut (
      .clk(clk), .reset(reset),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .perf_lsu_stall(perf_lsu_stall), .perf_if_stall(perf_if_stall),
      .perf_dma_stall(perf_dma_stall));

   function automatic logic [DATA_W-1:0] word_init(input int i);
      return {32'(i) ^ 32'h5A5A_0000, ~32'(i), 32'(i) * 32'd3, 32'hC0DE_0000 + 32'(i)};
   endfunction

   // Behavioural local store: one-cycle read latency, unwritten words hold word_init.
   logic [DATA_W-1:0] env_mem [0:(1<<LS_AW)-1];
   bit                env_wr  [0:(1<<LS_AW)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wr[mem_addr]  <= 1'b1;
         end else begin
            mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : word_init(int'(mem_addr));
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [DATA_W-1:0] ref_mem [int];
   int                m_starve, m_run, m_rv, last_w;
   logic [DATA_W-1:0] m_rv_data;
   logic [31:0]       p_lsu, p_if, p_dma;

   function automatic logic [DATA_W-1:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : word_init(a);
   endfunction

   function automatic int qidx(input logic [ADDR_W-1:0] addr);
      return int'(addr >> 4) & ((1 << LS_AW) - 1);
   endfunction

   task automatic model_reset();
      m_starve = 0; m_run = 0; m_rv = 0; m_rv_data = '0; last_w = 0;
      p_lsu = 0; p_if = 0; p_dma = 0;
   endtask

   // 0 none, 1 LSU, 2 IF, 3 DMA
   function automatic int pick();
      if (if_req && m_starve >= int'(STARVE_MAX)) return 2;
      if (dma_req && !(m_run >= int'(DMA_BURST_MAX) && (lsu_req || if_req))) return 3;
      if (lsu_req) return 1;
      if (if_req) return 2;
      return 0;
   endfunction

   // Called just after an active edge; checks the cycle at the falling edge, returns after the next edge.
   task automatic cycle(input bit use_tab = 1'b0, input logic [2:0] tab = 3'b000);
      int w, a;
      logic we;
      logic [DATA_W-1:0] wd;
      @(negedge clk);
      w = pick(); a = 0; we = 1'b0; wd = '0;
      if (w == 1) begin a = qidx(lsu_addr); we = lsu_we; wd = lsu_wdata; end
      if (w == 2) begin a = qidx(if_addr); end
      if (w == 3) begin a = qidx(dma_addr); we = dma_we; wd = dma_wdata; end
      chk("lsu_gnt", 128'(lsu_gnt), 128'(w == 1));
      chk("if_gnt", 128'(if_gnt), 128'(w == 2));
      chk("dma_gnt", 128'(dma_gnt), 128'(w == 3));
      if (use_tab) begin
         chk("tab_gnt", 128'({lsu_gnt, if_gnt, dma_gnt}), 128'(tab));
      end
      chk("mem_en", 128'(mem_en), 128'(w != 0));
      chk("mem_we", 128'(mem_we), 128'(we));
      chk("mem_addr", 128'(mem_addr), 128'(a));
      chk("mem_wdata", mem_wdata, wd);
      chk("lsu_rvalid", 128'(lsu_rvalid), 128'(m_rv == 1));
      chk("if_rvalid", 128'(if_rvalid), 128'(m_rv == 2));
      chk("dma_rvalid", 128'(dma_rvalid), 128'(m_rv == 3));
      if (m_rv != 0) chk("rdata", rdata, m_rv_data);
`ifdef LS_ARB_PERF_EN
      chk("perf_lsu", 128'(perf_lsu_stall), 128'(p_lsu));
      chk("perf_if", 128'(perf_if_stall), 128'(p_if));
      chk("perf_dma", 128'(perf_dma_stall), 128'(p_dma));
`else
      chk("perf_zero", 128'({perf_lsu_stall, perf_if_stall, perf_dma_stall}), '0);
`endif
      if (w != 0 && !we) begin m_rv = w; m_rv_data = ref_read(a); end
      else m_rv = 0;
      if (w != 0 && we) ref_mem[a] = wd;
      if (if_req && w != 2) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : int'(STARVE_MAX);
      else m_starve = 0;
      if (w == 3) m_run = (m_run < int'(DMA_BURST_MAX)) ? m_run + 1 : int'(DMA_BURST_MAX);
      else m_run = 0;
      if (lsu_req && w != 1) p_lsu++;
      if (if_req && w != 2) p_if++;
      if (dma_req && w != 3) p_dma++;
      last_w = w;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lsu_req = 1'b0; lsu_we = 1'b0; if_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      logic [ADDR_W-1:0] r;
      r = ADDR_W'($urandom);
      r[LS_AW+3:4] = LS_AW'($urandom_range(0, 31));
      return r;
   endfunction

   typedef struct {
      bit       lsu;
      bit       ifr;
      bit       dma;
      bit [2:0] exp_gnt;   // {lsu, if, dma}
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   initial begin
      vec_t vt [14];
      for (int i = 0; i < 10; i++) vt[i] = '{1, 1, 1, 3'b001};
      vt[4]  = '{1, 1, 1, 3'b100};
      vt[8]  = '{1, 1, 1, 3'b010};
      vt[10] = '{1, 1, 0, 3'b100};
      vt[11] = '{0, 1, 0, 3'b010};
      vt[12] = '{0, 1, 1, 3'b001};
      vt[13] = '{0, 0, 0, 3'b000};

      model_reset();
      // Reset holds every output at zero even with all requests raised.
      lsu_req = 1'b1; if_req = 1'b1; dma_req = 1'b1;
      #12;
      chk("rst_gnt", 128'({lsu_gnt, if_gnt, dma_gnt}), '0);
      chk("rst_rvalid", 128'({lsu_rvalid, if_rvalid, dma_rvalid}), '0);
      chk("rst_mem", 128'({mem_en, mem_we}), '0);
      chk("rst_rdata", rdata, '0);
      do_reset();

      // Single LSU load at 0x40
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h40;
      #1;
      chk("t1_gnt", 128'(lsu_gnt), 128'(1));
      chk("t1_mem_addr", 128'(mem_addr), 128'(4));
      cycle();
      lsu_req = 1'b0;
      chk("t1_rvalid", 128'(lsu_rvalid), 128'(1));
      chk("t1_rdata", rdata, word_init(4));

      // LSU store then IF read of the same quadword
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h10; lsu_wdata = {16{8'hAA}};
      cycle();
      lsu_req = 1'b0; lsu_we = 1'b0;
      chk("t2_no_lsu_rvalid", 128'(lsu_rvalid), 128'(0));
      if_req = 1'b1; if_addr = 32'h1C;
      cycle();
      if_req = 1'b0;
      chk("t2_if_rvalid", 128'(if_rvalid), 128'(1));
      chk("t2_rdata", rdata, {16{8'hAA}});
      chk("t2_lsu_rvalid", 128'(lsu_rvalid), 128'(0));
      cycle();

      // Vector table: continuous contention from reset
      do_reset();
      lsu_addr = 32'h100; if_addr = 32'h200; dma_addr = 32'h300;
      for (int i = 0; i < 14; i++) begin
         lsu_req = vt[i].lsu; if_req = vt[i].ifr; dma_req = vt[i].dma;
         cycle(1'b1, vt[i].exp_gnt);
      end

      // DMA alone never gets blocked
      idle_inputs();
      dma_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         dma_addr = 32'(i * 16);
         #1;
         chk("dma_alone_gnt", 128'(dma_gnt), 128'(1));
         cycle();
      end
      dma_req = 1'b0;
      cycle();

      // Async reset while a read return is pending
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h80;
      cycle();
      chk("ar_pre_rvalid", 128'(lsu_rvalid), 128'(1));
      #1 reset = 1'b0;
      #1;
      chk("ar_gnt", 128'({lsu_gnt, if_gnt, dma_gnt}), '0);
      chk("ar_rvalid", 128'({lsu_rvalid, if_rvalid, dma_rvalid}), '0);
      chk("ar_mem", 128'({mem_en, mem_we}), '0);
      chk("ar_rdata", rdata, '0);
      lsu_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("ar_post_rvalid", 128'(lsu_rvalid), 128'(0));
         cycle();
      end

      // LSU + DMA for 10 cycles
      do_reset();
      lsu_req = 1'b1; dma_req = 1'b1; lsu_addr = 32'h500; dma_addr = 32'h600;
      repeat (10) cycle();
      idle_inputs();
`ifdef LS_ARB_PERF_EN
      chk("perf10_lsu", 128'(perf_lsu_stall), 128'(8));
      chk("perf10_dma", 128'(perf_dma_stall), 128'(2));
`else
      chk("perf10_off", 128'({perf_lsu_stall, perf_if_stall, perf_dma_stall}), '0);
`endif

      // Randomized traffic honouring hold-until-grant
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!lsu_req || last_w == 1) begin
            lsu_req = ($urandom_range(0, 99) < 65);
            lsu_we = 1'($urandom);
            lsu_addr = rand_addr();
            lsu_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         if (!if_req || last_w == 2) begin
            if_req = ($urandom_range(0, 99) < 60);
            if_addr = rand_addr();
         end
         if (!dma_req || last_w == 3) begin
            dma_req = ($urandom_range(0, 99) < 75);
            dma_we = 1'($urandom);
            dma_addr = rand_addr();
            dma_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         cycle();
      end
      idle_inputs();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
